// File: rtl/mlp_train_sequencer.sv
// Training/inference sequencer for one 2-input MLP learning a logic-gate truth table.
// Optional build macro ACCURACY_TRACK_EN adds correct_count (final-epoch hit counter).
// sfp values are Q16.16 signed fixed point: ONE = 0x00010000, HALF = 0x00008000.
module mlp_train_sequencer #(
    parameter int          SAMPLES       = 4,
    parameter int          EPOCHS        = 10,
    parameter int          STEP_CYCLES   = 4,
    parameter logic [31:0] LEARNING_RATE = 32'h1999_999A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  gate_sel,
    input  logic        first_input,
    input  logic        second_input,
    input  logic [31:0] prediction,
    output logic [31:0] values0,
    output logic [31:0] values1,
    output logic [31:0] expected,
    output logic        training,
    output logic [31:0] learning_rate,
    output logic        busy,
    output logic        done,
    output logic [7:0]  epoch_count,
`ifdef ACCURACY_TRACK_EN
    output logic [2:0]  correct_count,
`endif
    output logic        output_led
);

    localparam logic [31:0] ONE  = 32'h0001_0000;
    localparam logic [31:0] HALF = 32'h0000_8000;

    localparam int                HOLD_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(STEP_CYCLES - 1);
    localparam logic [1:0]        LAST_IDX   = 2'(SAMPLES - 1);
    localparam logic [7:0]        EPOCH_LAST = 8'(EPOCHS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRESENT = 3'd1;
    localparam logic [2:0] S_HOLD    = 3'd2;
    localparam logic [2:0] S_NEXT    = 3'd3;
    localparam logic [2:0] S_INFER   = 3'd4;

    logic [2:0]        state_reg;
    logic [1:0]        gate_reg;
    logic [1:0]        idx_reg;
    logic [HOLD_W-1:0] hold_reg;
    logic [7:0]        epoch_reg;
    logic [31:0]       values0_reg;
    logic [31:0]       values1_reg;
    logic [31:0]       expected_reg;
    logic              training_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              led_reg;

    logic       accept;
    logic [1:0] gate_next;
    logic [1:0] idx_inc;
    logic [3:0] truth_row;
    logic       pred_high;

    assign accept    = start && ((state_reg == S_IDLE) || (state_reg == S_INFER));
    // Truth table follows the gate being latched this edge so row 0 is correct on restart.
    assign gate_next = accept ? gate_sel : gate_reg;
    assign idx_inc   = idx_reg + 2'd1;
    assign pred_high = $signed(prediction) > $signed(HALF);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_truth
            localparam logic IN0 = 1'((gi >> 1) & 1);
            localparam logic IN1 = 1'(gi & 1);
            assign truth_row[gi] = (gate_next == 2'd0) ? (IN0 & IN1) :
                                   (gate_next == 2'd1) ? (IN0 | IN1) :
                                   (gate_next == 2'd2) ? (IN0 ^ IN1) :
                                                         ~(IN0 & IN1);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            gate_reg     <= 2'd0;
            idx_reg      <= 2'd0;
            hold_reg     <= '0;
            epoch_reg    <= 8'd0;
            values0_reg  <= 32'd0;
            values1_reg  <= 32'd0;
            expected_reg <= 32'd0;
            training_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            led_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                gate_reg     <= gate_sel;
                idx_reg      <= 2'd0;
                hold_reg     <= '0;
                epoch_reg    <= 8'd0;
                state_reg    <= S_PRESENT;
                training_reg <= 1'b1;
                busy_reg     <= 1'b1;
                led_reg      <= 1'b0;
                values0_reg  <= 32'd0;
                values1_reg  <= 32'd0;
                expected_reg <= truth_row[0] ? ONE : 32'd0;
            end else begin
                case (state_reg)
                    S_IDLE: ;
                    S_PRESENT: begin
                        hold_reg  <= '0;
                        state_reg <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (hold_reg == HOLD_LAST) begin
                            state_reg <= S_NEXT;
                        end else begin
                            hold_reg <= hold_reg + 1'b1;
                        end
                    end
                    S_NEXT: begin
                        if (idx_reg != LAST_IDX) begin
                            idx_reg      <= idx_inc;
                            values0_reg  <= idx_inc[1] ? ONE : 32'd0;
                            values1_reg  <= idx_inc[0] ? ONE : 32'd0;
                            expected_reg <= truth_row[idx_inc] ? ONE : 32'd0;
                            state_reg    <= S_PRESENT;
                        end else begin
                            idx_reg   <= 2'd0;
                            epoch_reg <= epoch_reg + 8'd1;
                            if (epoch_reg == EPOCH_LAST) begin
                                state_reg    <= S_INFER;
                                training_reg <= 1'b0;
                                busy_reg     <= 1'b0;
                                done_reg     <= 1'b1;
                                expected_reg <= 32'd0;
                                values0_reg  <= first_input ? ONE : 32'd0;
                                values1_reg  <= second_input ? ONE : 32'd0;
                            end else begin
                                state_reg    <= S_PRESENT;
                                values0_reg  <= 32'd0;
                                values1_reg  <= 32'd0;
                                expected_reg <= truth_row[0] ? ONE : 32'd0;
                            end
                        end
                    end
                    S_INFER: begin
                        values0_reg <= first_input ? ONE : 32'd0;
                        values1_reg <= second_input ? ONE : 32'd0;
                        led_reg     <= pred_high;
                    end
                    default: begin
                        state_reg    <= S_IDLE;
                        training_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef ACCURACY_TRACK_EN
    logic [2:0] correct_reg;

    // Scores the prediction seen while each row of the final epoch is still presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            correct_reg <= 3'd0;
        end else if (accept) begin
            correct_reg <= 3'd0;
        end else if ((state_reg == S_NEXT) && (epoch_reg == EPOCH_LAST) &&
                     (pred_high == (expected_reg != 32'd0))) begin
            correct_reg <= correct_reg + 3'd1;
        end
    end

    assign correct_count = correct_reg;
`endif

    assign values0       = values0_reg;
    assign values1       = values1_reg;
    assign expected      = expected_reg;
    assign training      = training_reg;
    assign learning_rate = LEARNING_RATE;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign epoch_count   = epoch_reg;
    assign output_led    = led_reg;

endmodule
